// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// The FETCH_SKID_EN macro adds the HOLD state used by the optional skid buffer.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
`ifdef FETCH_SKID_EN
        ,
        ST_HOLD = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; an idle cycle inserts a bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pc4,
    output logic [XLEN-1:0] instr_r,
    output logic [XLEN-1:0] pc_r,
    output logic [XLEN-1:0] pc4_r,
    output logic            valid_r
);

    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP);

    // Bubbles carry zeroed PCs so an invalid slot never exposes a stale address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= NOP_W;
            pc_r    <= {XLEN{1'b0}};
            pc4_r   <= {XLEN{1'b0}};
            valid_r <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_W;
            pc_r    <= {XLEN{1'b0}};
            pc4_r   <= {XLEN{1'b0}};
            valid_r <= 1'b0;
        end else if (stall) begin
            instr_r <= instr_r;
            pc_r    <= pc_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end else if (load) begin
            instr_r <= load_instr;
            pc_r    <= load_pc;
            pc4_r   <= load_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= NOP_W;
            pc_r    <= {XLEN{1'b0}};
            pc4_r   <= {XLEN{1'b0}};
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding imem request, redirect kill and IF/ID register.
// Define FETCH_SKID_EN to keep a response that arrives under stallD instead of refetching it.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            br_en_E,
    input  logic [XLEN-1:0] br_target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc4_D,
    output logic            valid_D
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
    localparam logic [XLEN-1:0] ADDR_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_f_r;
    logic [XLEN-1:0] pc_req_r;
    logic            kill_r;
`ifdef FETCH_SKID_EN
    logic [XLEN-1:0] skid_r;
`endif

    logic            good_s;
    logic            load_s;
    logic            advance_s;
    logic [XLEN-1:0] load_instr_s;
    logic [XLEN-1:0] pc_req4_s;

    assign imem_req  = (state_r == ST_REQ) && !stallF;
    assign imem_addr = pc_f_r & ADDR_MASK;
    assign pc_req4_s = pc_req_r + PC_STEP;

    // A response is usable only in WAIT, when not killed and not overtaken by a same-cycle redirect.
    always_comb begin
        good_s       = (state_r == ST_WAIT) && imem_rvalid && !kill_r && !br_en_E;
        load_s       = 1'b0;
        load_instr_s = imem_rdata;
        if (good_s && !stallD) begin
            load_s       = 1'b1;
            load_instr_s = imem_rdata;
        end
`ifdef FETCH_SKID_EN
        else if ((state_r == ST_HOLD) && !stallD && !br_en_E) begin
            load_s       = 1'b1;
            load_instr_s = skid_r;
        end
`endif
        else begin
            load_s       = 1'b0;
            load_instr_s = imem_rdata;
        end
        advance_s = load_s && !flushD;
    end

    // Fetch FSM, PC, granted-address latch and kill flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_f_r   <= RESET_PC;
            pc_req_r <= RESET_PC;
            kill_r   <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_r   <= XLEN'(NOP);
`endif
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_REQ;
                ST_REQ: begin
                    if (imem_req && imem_gnt) begin
                        pc_req_r <= pc_f_r;
                        kill_r   <= br_en_E;
                        state_r  <= ST_WAIT;
                    end else begin
                        state_r  <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        kill_r <= 1'b0;
`ifdef FETCH_SKID_EN
                        if (good_s && stallD && !flushD) begin
                            skid_r  <= imem_rdata;
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_REQ;
                        end
`else
                        state_r <= ST_REQ;
`endif
                    end else begin
                        kill_r <= kill_r | br_en_E;
                    end
                end
`ifdef FETCH_SKID_EN
                ST_HOLD: begin
                    if (flushD || br_en_E || !stallD) begin
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
`endif
                default: state_r <= ST_IDLE;
            endcase

            // A dropped response leaves pc_f_r at the granted address, which replays it.
            if (br_en_E) begin
                pc_f_r <= br_target_E;
            end else if (advance_s) begin
                pc_f_r <= pc_req4_s;
            end else begin
                pc_f_r <= pc_f_r;
            end
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flushD),
        .stall      (stallD),
        .load       (load_s),
        .load_instr (load_instr_s),
        .load_pc    (pc_req_r),
        .load_pc4   (pc_req4_s),
        .instr_r    (instr_D),
        .pc_r       (pc_D),
        .pc4_r      (pc4_D),
        .valid_r    (valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with RESET_PC = 32'h100.
module tb_fetch_stage;

    localparam logic [31:0] NOPI = 32'h0000_0013;

    typedef struct {
        logic        sf, sd, fd, br;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] ei, ep, ep4;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF, stallD, flushD, br_en_E;
    logic [31:0] br_target_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D, pc_D, pc4_D;
    logic        valid_D;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .br_en_E(br_en_E), .br_target_E(br_target_E), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D),
        .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic sf, sd, fd, br, input logic [31:0] tgt,
                                input logic gnt, rv, input logic [31:0] rd,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] ei, ep, ep4);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.br = br; v.tgt = tgt;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.ei = ei; v.ep = ep; v.ep4 = ep4;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL step%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic chk_ifid(input int idx, input logic ev, input logic [31:0] ei, ep, ep4);
        chk("valid_D", idx, {31'd0, valid_D}, {31'd0, ev});
        chk("instr_D", idx, instr_D, ei);
        chk("pc_D", idx, pc_D, ep);
        chk("pc4_D", idx, pc4_D, ep4);
    endtask

    initial begin
        // sf sd fd br tgt | gnt rv rdata | req addr | valid instr pc pc4
        add(0,0,0,0,32'h0, 0,0,32'h0,          0,32'h100,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h100,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0000,  0,32'h100,      1,32'hAAAA_0000,32'h100,32'h104);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h104,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0001,  0,32'h104,      1,32'hAAAA_0001,32'h104,32'h108);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h108,      0,NOPI,32'h0,32'h0);
        add(0,0,0,1,32'h200, 0,0,32'h0,        0,32'h108,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0002,  0,32'h200,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h200,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0003,  0,32'h200,      1,32'hAAAA_0003,32'h200,32'h204);
        add(0,0,0,1,32'h10C, 0,0,32'h0,        1,32'h204,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,1,0,0,32'h0, 0,1,32'hAAAA_0004,  0,32'h10C,      0,NOPI,32'h0,32'h0);
`ifdef FETCH_SKID_EN
        add(0,1,0,0,32'h0, 0,0,32'h0,          0,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,1,0,0,32'h0, 0,0,32'h0,          0,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,0,32'h0,          0,32'h10C,      1,32'hAAAA_0004,32'h10C,32'h110);
`else
        add(0,1,0,0,32'h0, 0,0,32'h0,          1,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,1,0,0,32'h0, 0,0,32'h0,          1,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h10C,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0004,  0,32'h10C,      1,32'hAAAA_0004,32'h10C,32'h110);
`endif
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h110,      0,NOPI,32'h0,32'h0);
        add(0,1,1,0,32'h0, 0,1,32'hAAAA_0005,  0,32'h110,      0,NOPI,32'h0,32'h0);
        add(0,0,0,1,32'hFFFF_FFFC, 0,0,32'h0,  1,32'h110,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'hFFFF_FFFC,0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0006,  0,32'hFFFF_FFFC,1,32'hAAAA_0006,32'hFFFF_FFFC,32'h0);
        add(1,0,0,0,32'h0, 0,0,32'h0,          0,32'h0,        0,NOPI,32'h0,32'h0);
        add(1,0,0,0,32'h0, 1,0,32'h0,          0,32'h0,        0,NOPI,32'h0,32'h0);
        add(1,0,0,1,32'h300, 0,0,32'h0,        0,32'h0,        0,NOPI,32'h0,32'h0);
        add(1,0,0,0,32'h0, 0,0,32'h0,          0,32'h300,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h300,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0007,  0,32'h300,      1,32'hAAAA_0007,32'h300,32'h304);
        add(0,0,0,1,32'h400, 1,0,32'h0,        1,32'h304,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0008,  0,32'h400,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 1,0,32'h0,          1,32'h400,      0,NOPI,32'h0,32'h0);
        add(0,0,0,0,32'h0, 0,1,32'hAAAA_0009,  0,32'h400,      1,32'hAAAA_0009,32'h400,32'h404);
        add(0,1,0,0,32'h0, 0,0,32'h0,          1,32'h404,      1,32'hAAAA_0009,32'h400,32'h404);
        add(0,0,0,0,32'h0, 0,0,32'h0,          1,32'h404,      0,NOPI,32'h0,32'h0);

        rst_n = 1'b0;
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; br_en_E = 1'b0;
        br_target_E = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset values.
        repeat (2) @(negedge clk);
        n_vec++;
        chk("rst_req", 0, {31'd0, imem_req}, 32'd0);
        chk("rst_addr", 0, imem_addr, 32'h100);
        chk_ifid(0, 1'b0, NOPI, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stallF = vecs[i].sf; stallD = vecs[i].sd; flushD = vecs[i].fd;
            br_en_E = vecs[i].br; br_target_E = vecs[i].tgt;
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rd;
            n_vec++;
            #1;
            chk("imem_req", i + 1, {31'd0, imem_req}, {31'd0, vecs[i].ereq});
            chk("imem_addr", i + 1, imem_addr, vecs[i].eaddr);
            @(posedge clk); #1;
            chk_ifid(i + 1, vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ep4);
            @(negedge clk);
        end

        // Reset mid-transaction, then stray responses before any new grant are ignored.
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; br_en_E = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        imem_gnt = 1'b0; rst_n = 1'b0;
        #1; n_vec++;
        chk("midrst_req", 100, {31'd0, imem_req}, 32'd0);
        chk("midrst_addr", 100, imem_addr, 32'h100);
        chk_ifid(100, 1'b0, NOPI, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0000;
        #1; n_vec++;
        chk("idle_req", 101, {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("idle_stray", 101, {31'd0, valid_D}, 32'd0);
        @(negedge clk);
        #1; n_vec++;
        chk("req_req", 102, {31'd0, imem_req}, 32'd1);
        chk("req_addr", 102, imem_addr, 32'h100);
        @(posedge clk); #1;
        chk("req_stray", 102, {31'd0, valid_D}, 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0001;
        n_vec++;
        @(posedge clk); #1;
        chk_ifid(103, 1'b1, 32'hBBBB_0001, 32'h100, 32'h104);
        @(negedge clk);
        imem_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter XLEN, default 32, width of all address/data ports.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stallF  in  1  hold PC; no new fetch request.
REQ-006 stallD  in  1  hold IF/ID register.
REQ-007 flushD  in  1  clear IF/ID register to bubble.
REQ-008 br_en_E  in  1  redirect taken in Execute.
REQ-009 br_target_E  in  XLEN  redirect PC.
REQ-010 imem_req  out  1  fetch request valid.
REQ-011 imem_addr  out  XLEN  fetch address; word aligned.
REQ-012 imem_gnt  in  1  request accepted this cycle.
REQ-013 imem_rvalid  in  1  response valid; in order, at least 1 cycle after grant.
REQ-014 imem_rdata  in  XLEN  instruction word.
REQ-015 instr_D, pc_D, pc4_D  out  XLEN each  IF/ID contents.
REQ-016 valid_D  out  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL keep at most one outstanding imem request.
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD. HOLD exists only with FETCH_SKID_EN.
REQ-019 IDLE -> REQ unconditionally after one cycle; IDLE is entered only from reset.
REQ-020 REQ: imem_req=1 when !stallF, with imem_addr=pc_F. On imem_gnt, latch pc_req=pc_F and go to WAIT.
REQ-021 WAIT: imem_req=0. On imem_rvalid, go to REQ; with FETCH_SKID_EN and stallD=1, go to HOLD instead.
REQ-022 On a delivered response: IF/ID loads instr=imem_rdata, pc=pc_req, pc4=pc_req+4, valid=1; pc_F <= pc_req+4 unless redirected.
REQ-023 Cycles with no delivered response and !stallD: IF/ID loads bubble (instr=NOP 32'h0000_0013, valid_D=0).
REQ-024 br_en_E=1: pc_F <= br_target_E, regardless of stallF.
REQ-025 br_en_E=1 in WAIT sets a kill flag; the next response is discarded and the kill flag clears.
REQ-026 br_en_E=1 in REQ with imem_gnt=1 in the same cycle also sets the kill flag.
REQ-027 IF/ID priority: flushD > stallD > load.
REQ-028 flushD discards any response arriving in the same cycle and any HOLD contents; with FETCH_SKID_EN, HOLD -> REQ.
REQ-029 PC arithmetic SHALL be modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-030 stallF holds pc_F and suppresses imem_req in REQ; an outstanding response is still accepted in WAIT.

Reset
REQ-031 While rst_n=0: state=IDLE, pc_F=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, instr_D=NOP, pc_D=0, pc4_D=0, valid_D=0.
REQ-032 Deassertion mid-transaction: any later imem_rvalid without a granted request after reset SHALL be ignored.

Configuration
REQ-033 Macro FETCH_SKID_EN. When defined, a one-entry skid buffer captures a response arriving while stallD=1; state goes to HOLD; the buffer is delivered in the first cycle with stallD=0, then state goes to REQ.
REQ-034 Without FETCH_SKID_EN, a response arriving while stallD=1 is dropped; pc_F stays pc_req and the same address is refetched (replay).

Structure
REQ-035 riscv_pkg SHALL hold the NOP constant, the fetch_state_t enum and XLEN default.
REQ-036 The IF/ID register (stall/flush/load, valid bit) SHALL be sub-module if_id_reg.

Verification
REQ-037 Reset: RESET_PC=32'h100, release reset, gnt and rvalid each 1 cycle later -> imem_addr=32'h100, then 32'h104; pc_D=32'h100, pc4_D=32'h104, valid_D=1.
REQ-038 Redirect in WAIT: br_en_E=1, br_target_E=32'h200 while 32'h108 is outstanding -> 32'h108 response discarded, valid_D=0, next imem_addr=32'h200.
REQ-039 stallD=1 for 3 cycles at response of 32'h10C. With FETCH_SKID_EN -> instr delivered on the first cycle stallD=0, no refetch. Without it -> 32'h10C re-requested.
REQ-040 flushD and stallD both 1 with a response arriving -> instr_D=32'h0000_0013, valid_D=0.
REQ-041 Wrap: pc_F=32'hFFFF_FFFC fetched -> pc4_D=0 and next imem_addr=0.
REQ-042 stallF=1 in REQ for 4 cycles -> imem_req=0 and pc_F unchanged; br_en_E during the stall still loads pc_F.
